// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty flags and flush.
// Define FIFO_ERR_EN to add sticky io_overflow/io_underflow outputs.
module fifo_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] io_din,
  input  logic                  io_push,
  input  logic                  io_pop,
  input  logic                  io_flush,
  output logic [DATA_WIDTH-1:0] io_dout,
  output logic                  io_empty,
  output logic                  io_full,
  output logic                  io_almost_full,
  output logic                  io_almost_empty,
`ifdef FIFO_ERR_EN
  output logic                  io_overflow,
  output logic                  io_underflow,
`endif
  output logic [AW:0]           io_count
);

  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count;
  logic                  empty, full;
  logic                  push_ok, pop_ok, mem_we;

  // The extra MSB on each pointer distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    pop_ok   = io_pop & ~empty;
    push_ok  = io_push & (~full | io_pop);
    mem_we   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (io_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; a write is masked while reset is high so reset fully overrides push.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= io_din;
    end
  end

  assign io_dout         = mem_q[rd_ptr_q[AW-1:0]];
  assign io_empty        = empty;
  assign io_full         = full;
  assign io_count        = count;
  assign io_almost_full  = (count >= AFULL_LVL);
  assign io_almost_empty = (count <= AEMPTY_LVL);

`ifdef FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (io_flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (io_push && full && !io_pop) overflow_d = 1'b1;
      if (io_pop && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign io_overflow  = overflow_q;
  assign io_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (DEPTH=4, DATA_WIDTH=8) against a queue-based reference model.
module tb_fifo_param;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset, io_push, io_pop, io_flush;
  logic [DW-1:0] io_din, io_dout;
  logic          io_empty, io_full, io_almost_full, io_almost_empty;
  logic [AW:0]   io_count;
`ifdef FIFO_ERR_EN
  logic          io_overflow, io_underflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf;

  fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)) dut (
    .clk(clk), .reset(reset), .io_din(io_din), .io_push(io_push), .io_pop(io_pop),
    .io_flush(io_flush), .io_dout(io_dout), .io_empty(io_empty), .io_full(io_full),
    .io_almost_full(io_almost_full), .io_almost_empty(io_almost_empty),
`ifdef FIFO_ERR_EN
    .io_overflow(io_overflow), .io_underflow(io_underflow),
`endif
    .io_count(io_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the reference model across the edge, settle 1 time unit.
  task automatic cyc(input bit rst, input bit push, input bit pop, input bit flush,
                     input logic [DW-1:0] din);
    bit was_full, was_empty;
    reset = rst; io_push = push; io_pop = pop; io_flush = flush; io_din = din;
    @(posedge clk);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (rst || flush) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (push && was_full && !pop) m_ovf = 1;
      if (pop && was_empty) m_unf = 1;
      if (pop && !was_empty) void'(mq.pop_front());
      if (push && (!was_full || pop)) mq.push_back(din);
    end
    #1;
    reset = 0; io_push = 0; io_pop = 0; io_flush = 0;
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 8'hAA);
    n_tests++; if (io_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", io_count); end
    n_tests++; if (io_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", io_empty); end
    n_tests++; if (io_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", io_full); end
    n_tests++; if (io_almost_empty !== 1'b1 || io_almost_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_almost got ae=%b af=%b exp ae=1 af=0", io_almost_empty, io_almost_full);
    end
`ifdef FIFO_ERR_EN
    n_tests++; if (io_overflow !== 1'b0 || io_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got ovf=%b unf=%b exp 0 0", io_overflow, io_underflow);
    end
`endif
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, vals[i]);
      n_tests++; if (io_count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count got=%0d exp=%0d", io_count, i + 1); end
      n_tests++; if (io_almost_full !== (i + 1 >= 3)) begin n_fail++; $display("FAIL fill_afull got=%b exp=%b", io_almost_full, (i + 1 >= 3)); end
      n_tests++; if (io_full !== (i + 1 == 4)) begin n_fail++; $display("FAIL fill_full got=%b exp=%b", io_full, (i + 1 == 4)); end
      n_tests++; if (io_dout !== 8'h11) begin n_fail++; $display("FAIL fill_head got=%h exp=11", io_dout); end
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (io_dout !== vals[i]) begin n_fail++; $display("FAIL drain_dout got=%h exp=%h", io_dout, vals[i]); end
      cyc(0, 0, 1, 0, 8'h00);
    end
    n_tests++; if (io_empty !== 1'b1 || io_count !== 3'd0) begin
      n_fail++; $display("FAIL drain_empty got empty=%b count=%0d exp 1 0", io_empty, io_count);
    end
  endtask

  task automatic test_push_full();
    logic [DW-1:0] exp_order [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    cyc(0, 1, 0, 0, 8'h11); cyc(0, 1, 0, 0, 8'h22);
    cyc(0, 1, 0, 0, 8'h33); cyc(0, 1, 0, 0, 8'h44);
    cyc(0, 1, 0, 0, 8'h55);
    n_tests++; if (io_count !== 3'd4 || io_full !== 1'b1) begin
      n_fail++; $display("FAIL full_drop got count=%0d full=%b exp 4 1", io_count, io_full);
    end
`ifdef FIFO_ERR_EN
    n_tests++; if (io_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow got=%b exp=1", io_overflow); end
`endif
    cyc(0, 1, 1, 0, 8'h66);
    n_tests++; if (io_count !== 3'd4) begin n_fail++; $display("FAIL full_pushpop_count got=%0d exp=4", io_count); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (io_dout !== exp_order[i]) begin n_fail++; $display("FAIL full_order got=%h exp=%h", io_dout, exp_order[i]); end
      cyc(0, 0, 1, 0, 8'h00);
    end
  endtask

  task automatic test_empty_corner();
    cyc(0, 0, 1, 0, 8'h00);
    n_tests++; if (io_count !== 3'd0 || io_empty !== 1'b1) begin
      n_fail++; $display("FAIL empty_pop got count=%0d empty=%b exp 0 1", io_count, io_empty);
    end
`ifdef FIFO_ERR_EN
    n_tests++; if (io_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow got=%b exp=1", io_underflow); end
`endif
    cyc(0, 1, 1, 0, 8'h77);
    n_tests++; if (io_count !== 3'd1 || io_dout !== 8'h77) begin
      n_fail++; $display("FAIL empty_pushpop got count=%0d dout=%h exp 1 77", io_count, io_dout);
    end
    cyc(0, 0, 1, 0, 8'h00);
  endtask

  task automatic test_wrap();
    bit saw_full = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 8'($urandom));
      cyc(0, 1, 0, 0, 8'($urandom));
      saw_full |= io_full;
      for (int k = 0; k < 2; k++) begin
        n_tests++; if (io_dout !== mq[0]) begin n_fail++; $display("FAIL wrap_order got=%h exp=%h", io_dout, mq[0]); end
        cyc(0, 0, 1, 0, 8'h00);
      end
    end
    n_tests++; if (saw_full || io_empty !== 1'b1) begin
      n_fail++; $display("FAIL wrap_flags got saw_full=%b empty=%b exp 0 1", saw_full, io_empty);
    end
  endtask

  task automatic test_flush_reset();
    cyc(0, 1, 0, 0, 8'hA1); cyc(0, 1, 0, 0, 8'hA2); cyc(0, 1, 0, 0, 8'hA3);
    cyc(0, 0, 1, 0, 8'h00); cyc(0, 0, 1, 0, 8'h00); cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'hB1); cyc(0, 1, 0, 0, 8'hB2); cyc(0, 1, 0, 0, 8'hB3);
    cyc(0, 1, 0, 1, 8'hB4);
    n_tests++; if (io_count !== 3'd0 || io_empty !== 1'b1) begin
      n_fail++; $display("FAIL flush got count=%0d empty=%b exp 0 1", io_count, io_empty);
    end
`ifdef FIFO_ERR_EN
    n_tests++; if (io_overflow !== 1'b0 || io_underflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_err got ovf=%b unf=%b exp 0 0", io_overflow, io_underflow);
    end
`endif
    cyc(0, 1, 0, 0, 8'hC1);
    n_tests++; if (io_dout !== 8'hC1 || io_count !== 3'd1) begin
      n_fail++; $display("FAIL post_flush got dout=%h count=%0d exp C1 1", io_dout, io_count);
    end
    cyc(0, 1, 0, 0, 8'hC2);
    cyc(1, 1, 1, 0, 8'hC3);
    n_tests++; if (io_count !== 3'd0 || io_almost_empty !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset got count=%0d ae=%b exp 0 1", io_count, io_almost_empty);
    end
  endtask

  task automatic test_random();
    bit rst, fl;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      fl  = ($urandom_range(0, 99) < 4);
      if (mq.size() != 0) begin
        n_tests++; if (io_dout !== mq[0]) begin n_fail++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", i, io_dout, mq[0]); end
      end
      cyc(rst, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, fl, 8'($urandom));
      n_tests++;
      if (io_count !== 3'(mq.size()) || io_empty !== (mq.size() == 0) || io_full !== (mq.size() == DEPTH) ||
          io_almost_full !== (mq.size() >= 3) || io_almost_empty !== (mq.size() <= 1)) begin
        n_fail++;
        $display("FAIL rand_flags cyc=%0d got count=%0d e=%b f=%b af=%b ae=%b exp count=%0d",
                 i, io_count, io_empty, io_full, io_almost_full, io_almost_empty, mq.size());
      end
`ifdef FIFO_ERR_EN
      n_tests++; if (io_overflow !== m_ovf || io_underflow !== m_unf) begin
        n_fail++; $display("FAIL rand_err cyc=%0d got ovf=%b unf=%b exp %b %b", i, io_overflow, io_underflow, m_ovf, m_unf);
      end
`endif
    end
  endtask

  initial begin
    reset = 1; io_push = 0; io_pop = 0; io_flush = 0; io_din = '0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_push_full();
    test_empty_corner();
    test_wrap();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's fixed 2-entry, 2-bit FIFO.
- Adds configurable width and depth, an occupancy count, almost-full/almost-empty flags, a synchronous flush, and push-while-full when a pop happens in the same cycle.
- Used as the generic buffering primitive between pipeline stages in the generated designs.

Parameters:
- DATA_WIDTH, 8: payload width in bits; must be >= 1.
- DEPTH, 4: number of entries; power of two, >= 2.
- AFULL_LEVEL, DEPTH-1: io_almost_full asserts when count >= AFULL_LEVEL; range 1..DEPTH.
- AEMPTY_LEVEL, 1: io_almost_empty asserts when count <= AEMPTY_LEVEL; range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- io_din  in  DATA_WIDTH  write data.
- io_push  in  1  write request.
- io_pop  in  1  read request.
- io_flush  in  1  synchronous clear of FIFO contents.
- io_dout  out  DATA_WIDTH  head-of-queue data.
- io_empty  out  1  count == 0.
- io_full  out  1  count == DEPTH.
- io_almost_full  out  1  count >= AFULL_LEVEL.
- io_almost_empty  out  1  count <= AEMPTY_LEVEL.
- io_count  out  AW+1  occupancy 0..DEPTH, where AW = $clog2(DEPTH).

Behaviour:
- State:
  - rd_ptr and wr_ptr, each AW+1 bits; the MSB is the wrap bit.
  - Storage array mem[DEPTH] of DATA_WIDTH bits. The memory is not reset.
- Flags derive from the pointers: empty = (wr_ptr == rd_ptr); full = (low AW bits equal) && (MSBs differ). io_count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- All outputs are functions of registered state only. There is no combinational path from any input to any output.
- Reset (reset=1 at the clock edge):
  - Pointers go to 0.
  - Outputs after reset: io_empty=1, io_full=0, io_count=0, io_almost_empty=1 (AEMPTY_LEVEL >= 0), io_almost_full=0.
  - io_dout is unspecified.
  - reset overrides flush, push and pop.
- Flush (io_flush=1, reset=0): pointers go to 0 at the next edge. Push and pop in the same cycle are ignored. No memory write occurs.
- pop_ok = io_pop & !empty. A pop while empty is ignored with no state change.
- push_ok = io_push & (!full | io_pop). A push while full is accepted only if a pop is also requested; a pop is always valid when full. Otherwise the push is dropped.
- When push and pop arrive together while empty, only the push is accepted. There is no bypass, so the popped data is not the pushed data.
- On push_ok: mem[wr_ptr[AW-1:0]] <= io_din; wr_ptr increments by 1.
- On pop_ok: rd_ptr increments by 1.
- Pointers wrap naturally at 2^(AW+1).
- io_dout = mem[rd_ptr[AW-1:0]]; this is an asynchronous read of the head entry. It is valid whenever io_empty=0 and changes in the cycle after a pop.
- Latency: data pushed at edge N is visible on io_dout after edge N, provided the FIFO was empty. io_empty deasserts after the same edge.
- Simultaneous push_ok and pop_ok leaves the count unchanged.

Optional Feature:
- Macro: FIFO_ERR_EN.
- When defined, the block adds outputs io_overflow (1 bit) and io_underflow (1 bit), both sticky:
  - io_overflow sets at the edge after a dropped push (io_push & full & !io_pop).
  - io_underflow sets at the edge after io_pop while empty.
  - Both clear only on reset or io_flush.
  - Both reset to 0.
- When not defined, these ports do not exist and dropped requests are silent. All other behaviour is identical.

Test Plan (DATA_WIDTH=8, DEPTH=4, AFULL_LEVEL=3, AEMPTY_LEVEL=1):
- Fill and drain:
  - Stimulus: hold reset for 1 cycle, push 0x11, 0x22, 0x33, 0x44.
  - Response: io_count steps 1→4; io_almost_full=1 at count 3; io_full=1 at count 4.
  - Then pop 4 times. Response: io_dout reads 0x11, 0x22, 0x33, 0x44 in order; io_empty=1 at the end.
- Push while full:
  - Stimulus: with the FIFO full, push 0x55 without pop.
  - Response: ignored; count stays 4; FIFO_ERR_EN build shows io_overflow=1.
  - Stimulus: then push 0x66 and pop together. Response: count stays 4, head becomes 0x22, 0x66 is the last entry popped.
- Empty-side corner:
  - Stimulus: pop while empty.
  - Response: count stays 0; io_underflow=1 when FIFO_ERR_EN is defined.
  - Stimulus: push 0x77 with pop while empty. Response: count=1, io_dout=0x77.
- Wrap-around:
  - Stimulus: run 10 push/pop pairs interleaved with count oscillating 0..2.
  - Response: data order is preserved across pointer wrap; io_full never asserts.
- Flush and reset mid-operation:
  - Stimulus: at count 3, assert io_flush together with a push.
  - Response: next cycle count=0, io_empty=1, the push is lost, error flags clear.
  - Stimulus: refill to 2, assert reset with push and pop. Response: count=0, io_almost_empty=1.
